// File: rtl/servo_spi_sequencer_pkg.sv
// Shared opcodes, state encoding and frame helpers for the SPI-to-servo sequencer.
package servo_spi_sequencer_pkg;

  localparam logic [1:0] OP_SINGLE = 2'b00;
  localparam logic [1:0] OP_BCAST  = 2'b01;

  localparam logic [2:0] ENC_HDR   = 3'd0;
  localparam logic [2:0] ENC_DHI   = 3'd1;
  localparam logic [2:0] ENC_DLO   = 3'd2;
  localparam logic [2:0] ENC_CHK   = 3'd3;
  localparam logic [2:0] ENC_ISSUE = 3'd4;

  typedef enum logic [2:0] {
    ST_HDR   = ENC_HDR,
    ST_DHI   = ENC_DHI,
    ST_DLO   = ENC_DLO,
    ST_CHK   = ENC_CHK,
    ST_ISSUE = ENC_ISSUE
  } state_t;

  // Opcodes 10/11 are reserved; they are only rejected once the whole frame is in.
  function automatic logic is_legal_op(input logic [1:0] op);
    return (op == OP_SINGLE) || (op == OP_BCAST);
  endfunction

endpackage

// File: rtl/servo_spi_sequencer_if.sv
// Byte input from the SPI receiver plus the cs/addr/data load bus and status.
interface servo_spi_sequencer_if #(
  parameter int ADDRESS_BIT_WIDTH = 2,
  parameter int SIGNAL_BIT_WIDTH  = 16
);
  logic                         rx_valid;
  logic [7:0]                   rx_byte;
  logic                         cs;
  logic [ADDRESS_BIT_WIDTH-1:0] addr;
  logic [SIGNAL_BIT_WIDTH-1:0]  data;
  logic                         busy;
  logic                         err;
  logic [7:0]                   err_count;

  // Sequencer side: consumes bytes, drives the load bus.
  modport master (
    input  rx_valid, rx_byte,
    output cs, addr, data, busy, err, err_count
  );

  // Environment side: supplies bytes, observes the load bus.
  modport slave (
    output rx_valid, rx_byte,
    input  cs, addr, data, busy, err, err_count
  );
endinterface

// File: rtl/servo_frame_timeout.sv
// Inter-byte inactivity timer for SPI command framers.
// expire is asserted while enabled and the count sits at TIMEOUT_CYCLES-1.
module servo_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,     // synchronous, active-low
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  assign expire = enable && (count_reg == LIMIT);

  // Count idle cycles; any clear, a disabled phase or an expiry restarts from zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear || !enable || expire) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end
endmodule

// File: rtl/servo_spi_sequencer.sv
// Assembles 4-byte SPI command frames, validates the XOR checksum and drives
// single or broadcast register writes onto the servo controller load bus.
module servo_spi_sequencer
  import servo_spi_sequencer_pkg::*;
#(
  parameter int SIGNAL_BIT_WIDTH  = 16,
  parameter int ADDRESS_BIT_WIDTH = 2,
  parameter int PWM_SIGNAL_COUNT  = 4,
  parameter int TIMEOUT_CYCLES    = 100000
) (
  input logic                    clk,
  input logic                    rst,   // synchronous, active-low
  servo_spi_sequencer_if.master  bus
);
  localparam logic [ADDRESS_BIT_WIDTH-1:0] LAST_ADDR = ADDRESS_BIT_WIDTH'(PWM_SIGNAL_COUNT - 1);

  state_t                       state_reg, state_next;
  logic [7:0]                   hdr_reg, hdr_next;
  logic [7:0]                   dhi_reg, dhi_next;
  logic [7:0]                   dlo_reg, dlo_next;
  logic                         cs_reg, cs_next;
  logic [ADDRESS_BIT_WIDTH-1:0] addr_reg, addr_next;
  logic [SIGNAL_BIT_WIDTH-1:0]  data_reg, data_next;
  logic                         busy_reg, busy_next;
  logic                         err_reg, err_next;
  logic [7:0]                   err_count_reg;
  logic                         tmo_enable, tmo_expire;
  logic                         frame_ok;

  assign tmo_enable = (state_reg == ST_DHI) || (state_reg == ST_DLO) || (state_reg == ST_CHK);

  servo_frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.rx_valid),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );

  // Checksum byte arrives live in CHK, so validate against rx_byte directly.
  assign frame_ok = ((hdr_reg ^ dhi_reg ^ dlo_reg ^ bus.rx_byte) == 8'h00) && is_legal_op(hdr_reg[7:6]);

  // Frame FSM: next state and the next value of every registered output.
  always_comb begin
    state_next = state_reg;
    hdr_next   = hdr_reg;
    dhi_next   = dhi_reg;
    dlo_next   = dlo_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    cs_next    = 1'b0;
    busy_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      ST_HDR: begin
        if (bus.rx_valid) begin
          hdr_next   = bus.rx_byte;
          state_next = ST_DHI;
        end
      end
      ST_DHI: begin
        if (bus.rx_valid) begin
          dhi_next   = bus.rx_byte;
          state_next = ST_DLO;
        end else if (tmo_expire) begin
          err_next   = 1'b1;
          state_next = ST_HDR;
        end
      end
      ST_DLO: begin
        if (bus.rx_valid) begin
          dlo_next   = bus.rx_byte;
          state_next = ST_CHK;
        end else if (tmo_expire) begin
          err_next   = 1'b1;
          state_next = ST_HDR;
        end
      end
      ST_CHK: begin
        if (bus.rx_valid) begin
          if (frame_ok) begin
            state_next = ST_ISSUE;
            cs_next    = 1'b1;
            busy_next  = 1'b1;
            data_next  = {dhi_reg, dlo_reg};
            addr_next  = (hdr_reg[7:6] == OP_BCAST) ? '0 : hdr_reg[ADDRESS_BIT_WIDTH-1:0];
          end else begin
            err_next   = 1'b1;
            state_next = ST_HDR;
          end
        end else if (tmo_expire) begin
          err_next   = 1'b1;
          state_next = ST_HDR;
        end
      end
      ST_ISSUE: begin
        // Bytes arriving while writes are in flight are discarded as overruns.
        err_next = bus.rx_valid;
        if ((hdr_reg[7:6] == OP_BCAST) && (addr_reg != LAST_ADDR)) begin
          cs_next   = 1'b1;
          busy_next = 1'b1;
          addr_next = addr_reg + 1'b1;
        end else begin
          state_next = ST_HDR;
        end
      end
      default: state_next = ST_HDR;
    endcase
  end

  // State, byte latches and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_HDR;
      hdr_reg   <= '0;
      dhi_reg   <= '0;
      dlo_reg   <= '0;
      cs_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      hdr_reg   <= hdr_next;
      dhi_reg   <= dhi_next;
      dlo_reg   <= dlo_next;
      cs_reg    <= cs_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  // Saturating error counter, updated alongside the err pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count_reg <= '0;
    end else if (err_next && (err_count_reg != 8'hFF)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign bus.cs        = cs_reg;
  assign bus.addr      = addr_reg;
  assign bus.data      = data_reg;
  assign bus.busy      = busy_reg;
  assign bus.err       = err_reg;
  assign bus.err_count = err_count_reg;
endmodule

// File: doc/servo_spi_sequencer.md
Name: servo_spi_sequencer

Overview:
Converts the byte stream from the SPI slave receiver into register writes on the servo controller's cs/addr/data load bus. Assembles 4-byte command frames, validates them by XOR checksum, then issues either one load strobe or a broadcast sequence covering every PWM channel. A per-frame inactivity timeout discards partial frames. Sits between the SPI slave and the servo controller.

Parameters:
SIGNAL_BIT_WIDTH, 16, width of the pulse-width word driven on data; fixed at 16 because a frame carries exactly 2 data bytes.
ADDRESS_BIT_WIDTH, 2, width of the channel address.
PWM_SIGNAL_COUNT, 4, number of channels written by a broadcast; must be <= 2^ADDRESS_BIT_WIDTH.
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between consecutive bytes of one frame; must be >= 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
rx_valid  input  1  one-cycle strobe: rx_byte is valid
rx_byte  input  8  received SPI byte
cs  output  1  load strobe to servo controller, one cycle per write
addr  output  ADDRESS_BIT_WIDTH  channel address, valid while cs=1
data  output  SIGNAL_BIT_WIDTH  pulse-width word, valid while cs=1
busy  output  1  high in ISSUE state
err  output  1  one-cycle pulse on any frame error
err_count  output  8  saturating error counter

Behaviour:
- Reset (rst=0 at a clk edge): state=HDR, cs=0, addr=0, data=0, busy=0, err=0, err_count=0, timeout counter=0. Reset mid-frame or mid-broadcast aborts it immediately; no further cs pulses are issued.
- Frame layout, in order:
  - B0 header: [7:6] opcode (00 = single write, 01 = broadcast, 10/11 = illegal); [5:ADDRESS_BIT_WIDTH] ignored; [ADDRESS_BIT_WIDTH-1:0] address.
  - B1: data[15:8].
  - B2: data[7:0].
  - B3: checksum. The frame is valid when B0^B1^B2^B3 == 0.
- States: HDR -> DHI -> DLO -> CHK -> ISSUE -> HDR.
  - Each of the first four transitions fires on rx_valid. The byte is latched in the same cycle.
  - An illegal opcode is not checked in HDR. It is detected in CHK and counts as an error.
- CHK transition on rx_valid:
  - Checksum OK and opcode legal -> ISSUE.
  - Otherwise -> HDR, with err pulsed for 1 cycle.
- ISSUE, single write: cs=1 for exactly one cycle, starting the cycle after B3 is accepted (latency 1). addr=header address, data={B1,B2}. Returns to HDR next cycle.
- ISSUE, broadcast: PWM_SIGNAL_COUNT consecutive cycles with cs=1, addr=0,1,...,N-1, data constant. Returns to HDR after the last write. The header address is ignored.
- busy=1 exactly during the ISSUE cycles.
- rx_valid during ISSUE: the byte is dropped and err pulses. The dropped byte is not used as the next header.
- addr/data hold their last values while cs=0.
- Timeout:
  - The counter clears on every accepted byte and increments each cycle while in DHI, DLO or CHK.
  - Reaching TIMEOUT_CYCLES-1 without rx_valid -> HDR, err pulse, counter cleared.
  - rx_valid in the same cycle the limit is reached: the byte wins and the timeout does not fire.
  - The counter is held at 0 in HDR and ISSUE.
- err_count increments on each err pulse and saturates at 255 with no wrap.
- All outputs are registered.

Decomposition:
- Shared package: opcode constants (OP_SINGLE=2'b00, OP_BCAST=2'b01) and state encoding localparams.
- Sub-module: servo_frame_timeout (counter, clear/enable inputs, expire output). It is reusable by other SPI command sequencers.
- The FSM, byte latches and broadcast address counter stay in the top module.

Test Plan:
1. Single write: bytes 0x02,0x05,0xDC,0xDB -> one cs pulse one cycle after the last rx_valid, addr=2, data=0x05DC, err=0.
2. Broadcast: 0x40,0x03,0xE8,0xAB -> 4 consecutive cs cycles, addr 0,1,2,3, data=0x03E8 each, busy=1 for those 4 cycles only.
3. Bad checksum: 0x01,0x05,0xDC,0x00 -> no cs, err pulse, err_count=1. The following valid frame 0x01,0x05,0xDC,0xD8 writes addr=1, data=0x05DC.
4. Timeout (TIMEOUT_CYCLES=16): 0x00,0x12, then idle 20 cycles -> err pulse, err_count=1. Then 0x03,0x00,0x10,0x13 writes addr=3, data=0x0010.
5. Overrun/illegal: a byte during broadcast ISSUE -> err pulse, all 4 writes complete. Frame 0x80,0x00,0x00,0x80 -> err pulse, no cs.
6. Reset during broadcast (rst=0 on the 2nd cs cycle) -> cs=0 the next cycle, all outputs at reset values. Then 300 bad frames -> err_count stays at 255.
